// File: rtl/mem_access_controller_if.sv
// -----------------------------------------------------------------------------
// mem_access_controller_if
//   Request/ready bus between the M-stage access controller and a
//   variable-latency data memory.
//
//   dmem_req    request valid (controller -> memory)
//   dmem_we     1=write, 0=read
//   dmem_addr   word-aligned byte address {addr[31:2],2'b00}
//   dmem_be     byte-lane enables
//   dmem_wdata  store data already shifted onto its byte lanes
//   dmem_ready  memory accepts/completes the current request (memory -> ctrl)
//   dmem_rdata  read word, valid while dmem_ready=1
//
//   master: the controller side; slave: the memory side.
// -----------------------------------------------------------------------------
interface mem_access_controller_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_access_controller.sv
// -----------------------------------------------------------------------------
// mem_access_controller
//   Sequences the data-memory access of the instruction sitting in the M stage.
//   Decodes load/store, size and alignment, runs the req/ready handshake,
//   freezes F/D/E/M through stall_M while the access is in flight, and returns
//   byte-lane-aligned, sign/zero-extended load data.
//
// Ports
//   CLK, RESET     clock (posedge) and asynchronous active-high reset
//   result_src_M   M-stage result select; == LOAD_SRC marks a load
//   mem_write_M    M-stage store enable (wins over load)
//   funct3_M       [1:0] size 00=B 01=H 10/11=W; [2]=1 unsigned load
//   alu_result_M   effective byte address
//   store_data_M   store data (rs2)
//   dmem           master side of the data-memory bus
//   stall_M        hold all pipeline registers up to and including M
//   load_data_M    extended load result, valid in DONE
//   mem_fault      one-cycle fault pulse, registered
//   fault_cause    01=misaligned 10=timeout; held until the next fault
// -----------------------------------------------------------------------------
module mem_access_controller #(
    parameter logic [2:0] LOAD_SRC = 3'b001,
    parameter int         TIMEOUT  = 16,
    parameter int         CNT_W    = 5
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [2:0]                result_src_M,
    input  logic                      mem_write_M,
    input  logic [2:0]                funct3_M,
    input  logic [31:0]               alu_result_M,
    input  logic [31:0]               store_data_M,
    mem_access_controller_if.master   dmem,
    output logic                      stall_M,
    output logic [31:0]               load_data_M,
    output logic                      mem_fault,
    output logic [1:0]                fault_cause
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      addr_q;
    logic             we_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    logic [2:0]       funct3_q;
    logic [1:0]       off_q;
    logic [31:0]      load_data_q;
    logic             mem_fault_q;
    logic [1:0]       fault_cause_q;

    // ---------------------------------------------------------------- decode
    logic        is_store, is_load, access, misaligned;
    logic [1:0]  size, off;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;

    assign is_store   = mem_write_M;
    assign is_load    = (result_src_M == LOAD_SRC);
    assign access     = is_store | is_load;
    assign size       = funct3_M[1:0];
    assign off        = alu_result_M[1:0];
    // size[1] covers both 10 and 11, so the reserved size behaves as a word.
    assign misaligned = ((size == 2'b01) & off[0]) | (size[1] & (off != 2'b00));
    assign wdata_calc = store_data_M << {off, 3'b000};

    always_comb begin
        case (size)
            2'b00:   be_calc = 4'b0001 << off;
            2'b01:   be_calc = 4'b0011 << off;
            default: be_calc = 4'b1111;
        endcase
    end

    // ------------------------------------------------------- load extension
    // Uses the latched offset/funct3: the M-stage fields are frozen anyway,
    // but the latched copy keeps the result independent of pipeline inputs.
    logic [31:0] rd_shift, load_ext;

    assign rd_shift = dmem.dmem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   load_ext = funct3_q[2] ? {24'h0, rd_shift[7:0]}
                                            : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_ext = funct3_q[2] ? {16'h0, rd_shift[15:0]}
                                            : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: load_ext = rd_shift;
        endcase
    end

    // --------------------------------------------------- next state / stall
    logic start, complete, timeout, misalign_fault;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a variable unassigned and no latch is inferred.
        state_d        = state_q;
        stall_M        = 1'b0;
        start          = 1'b0;
        complete       = 1'b0;
        timeout        = 1'b0;
        misalign_fault = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        misalign_fault = 1'b1;
                    end else begin
                        start   = 1'b1;
                        stall_M = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // Ready is checked first so a ready in the limit cycle completes.
                if (dmem.dmem_ready) begin
                    complete = 1'b1;
                    stall_M  = 1'b1;
                    state_d  = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // Stall drops here so the faulting instruction leaves M at
                    // this edge instead of being re-issued from IDLE.
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall_M = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            we_q          <= 1'b0;
            be_q          <= '0;
            wdata_q       <= '0;
            funct3_q      <= '0;
            off_q         <= '0;
            load_data_q   <= '0;
            mem_fault_q   <= 1'b0;
            fault_cause_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order in this block.
            state_q <= state_d;

            if (start) begin
                addr_q   <= {alu_result_M[31:2], 2'b00};
                we_q     <= is_store;
                be_q     <= be_calc;
                wdata_q  <= wdata_calc;
                funct3_q <= funct3_M;
                off_q    <= off;
                cnt_q    <= '0;
            end else if (state_q == REQ) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (complete && !we_q) begin
                load_data_q <= load_ext;
            end

            mem_fault_q <= misalign_fault | timeout;
            if (misalign_fault) begin
                fault_cause_q <= CAUSE_MISALIGN;
            end else if (timeout) begin
                fault_cause_q <= CAUSE_TIMEOUT;
            end
        end
    end

    // -------------------------------------------------------------- outputs
    // dmem_req decodes the state register, so an async reset drops it at once.
    assign dmem.dmem_req   = (state_q == REQ);
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;
    assign load_data_M     = load_data_q;
    assign mem_fault       = mem_fault_q;
    assign fault_cause     = fault_cause_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// -----------------------------------------------------------------------------
// tb_mem_access_controller
//   Directed bench for mem_access_controller. Inputs change 2 time units after
//   each rising edge; outputs are sampled 1-2 units later, well before the
//   next edge. The bench plays the memory by driving dmem_ready/dmem_rdata.
// -----------------------------------------------------------------------------
module tb_mem_access_controller;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [2:0]  result_src_M;
    logic        mem_write_M;
    logic [2:0]  funct3_M;
    logic [31:0] alu_result_M;
    logic [31:0] store_data_M;
    logic        stall_M;
    logic [31:0] load_data_M;
    logic        mem_fault;
    logic [1:0]  fault_cause;

    int checks = 0;
    int errors = 0;
    int n_req;
    int n_stall;

    mem_access_controller_if bus ();

    mem_access_controller #(
        .LOAD_SRC (3'b001),
        .TIMEOUT  (16),
        .CNT_W    (5)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .result_src_M (result_src_M),
        .mem_write_M  (mem_write_M),
        .funct3_M     (funct3_M),
        .alu_result_M (alu_result_M),
        .store_data_M (store_data_M),
        .dmem         (bus.master),
        .stall_M      (stall_M),
        .load_data_M  (load_data_M),
        .mem_fault    (mem_fault),
        .fault_cause  (fault_cause)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input logic [2:0] rs, input logic mw, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd);
        result_src_M = rs;
        mem_write_M  = mw;
        funct3_M     = f3;
        alu_result_M = a;
        store_data_M = sd;
    endtask

    task automatic nop();
        set_m(3'b000, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #2;
        bus.dmem_ready = 1'b0;
    endtask

    // Steps cycles while stall_M is high, raising dmem_ready in the rdy_at-th
    // REQ cycle (0 = never). Returns in the first cycle with stall_M low.
    task automatic run(input int rdy_at, input logic [31:0] rdata,
                       output int nr, output int ns);
        nr = 0;
        ns = 0;
        bus.dmem_rdata = rdata;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus.dmem_req) begin
                nr++;
                bus.dmem_ready = (nr == rdy_at);
            end
            #1;
            if (!stall_M) return;
            ns++;
            next_cycle();
        end
        checks++;
        errors++;
        $error("FAIL run_bound: stall_M still high after 40 cycles, required low");
    endtask

    initial begin
        RESET          = 1'b1;
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = 32'h0;
        nop();

        // ---- reset state
        @(posedge CLK);
        #2;
        check("rst_req",   bus.dmem_req,   32'h0);
        check("rst_we",    bus.dmem_we,    32'h0);
        check("rst_be",    bus.dmem_be,    32'h0);
        check("rst_addr",  bus.dmem_addr,  32'h0);
        check("rst_wdata", bus.dmem_wdata, 32'h0);
        check("rst_load",  load_data_M,    32'h0);
        check("rst_fault", mem_fault,      32'h0);
        check("rst_cause", fault_cause,    32'h0);
        check("rst_stall", stall_M,        32'h0);
        RESET = 1'b0;
        next_cycle();

        // ---- 1: LW 0x100, ready in first REQ cycle
        set_m(3'b001, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
        run(1, 32'hDEAD_BEEF, n_req, n_stall);
        check("lw_nreq",   n_req,          32'd1);
        check("lw_nstall", n_stall,        32'd2);
        check("lw_done_req", bus.dmem_req, 32'h0);
        check("lw_be",     bus.dmem_be,    32'hF);
        check("lw_we",     bus.dmem_we,    32'h0);
        check("lw_addr",   bus.dmem_addr,  32'h0000_0100);
        check("lw_data",   load_data_M,    32'hDEAD_BEEF);
        next_cycle();
        nop();

        // ---- 2: LB / LBU 0x103
        set_m(3'b001, 1'b0, 3'b000, 32'h0000_0103, 32'h0);
        run(1, 32'h8011_2233, n_req, n_stall);
        check("lb_be",   bus.dmem_be,   32'h8);
        check("lb_addr", bus.dmem_addr, 32'h0000_0100);
        check("lb_data", load_data_M,   32'hFFFF_FF80);
        next_cycle();
        set_m(3'b001, 1'b0, 3'b100, 32'h0000_0103, 32'h0);
        run(1, 32'h8011_2233, n_req, n_stall);
        check("lbu_data", load_data_M,  32'h0000_0080);
        next_cycle();

        // ---- LH 0x102 signed, upper half
        set_m(3'b001, 1'b0, 3'b001, 32'h0000_0102, 32'h0);
        run(1, 32'h8001_0000, n_req, n_stall);
        check("lh_be",   bus.dmem_be, 32'hC);
        check("lh_data", load_data_M, 32'hFFFF_8001);
        next_cycle();

        // ---- 3: SH 0x202, ready after 3 REQ cycles
        set_m(3'b000, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD);
        run(3, 32'h5555_5555, n_req, n_stall);
        check("sh_nreq",   n_req,          32'd3);
        check("sh_nstall", n_stall,        32'd4);
        check("sh_we",     bus.dmem_we,    32'h1);
        check("sh_be",     bus.dmem_be,    32'hC);
        check("sh_addr",   bus.dmem_addr,  32'h0000_0200);
        check("sh_wdata",  bus.dmem_wdata, 32'hABCD_0000);
        check("sh_load_kept", load_data_M, 32'hFFFF_8001);
        next_cycle();
        nop();

        // ---- 4: misaligned LW 0x101
        set_m(3'b001, 1'b0, 3'b010, 32'h0000_0101, 32'h0);
        run(1, 32'h0, n_req, n_stall);
        check("mis_nreq",   n_req,   32'd0);
        check("mis_nstall", n_stall, 32'd0);
        next_cycle();
        nop();
        #1;
        check("mis_fault", mem_fault,   32'h1);
        check("mis_cause", fault_cause, 32'h1);
        next_cycle();
        #1;
        check("mis_pulse_end", mem_fault,   32'h0);
        check("mis_cause_held", fault_cause, 32'h1);

        // ---- 5: SW that never gets ready -> timeout
        set_m(3'b000, 1'b1, 3'b010, 32'h0000_0300, 32'h1122_3344);
        run(0, 32'h0, n_req, n_stall);
        check("to_nreq",   n_req,        32'd16);
        check("to_nstall", n_stall,      32'd16);
        check("to_req_last", bus.dmem_req, 32'h1);
        next_cycle();
        nop();
        #1;
        check("to_fault", mem_fault,    32'h1);
        check("to_cause", fault_cause,  32'h2);
        check("to_idle_req", bus.dmem_req, 32'h0);
        next_cycle();
        #1;
        check("to_pulse_end", mem_fault, 32'h0);

        // ---- ready in the limit cycle wins over timeout
        set_m(3'b001, 1'b0, 3'b010, 32'h0000_0104, 32'h0);
        run(16, 32'h1234_5678, n_req, n_stall);
        check("rw_nreq",   n_req,       32'd16);
        check("rw_nstall", n_stall,     32'd17);
        check("rw_data",   load_data_M, 32'h1234_5678);
        next_cycle();
        nop();
        #1;
        check("rw_no_fault",  mem_fault,   32'h0);
        check("rw_cause_held", fault_cause, 32'h2);
        next_cycle();

        // ---- 6: reset mid-REQ, then a normal LW
        set_m(3'b001, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
        next_cycle();
        #1;
        check("mr_req_before", bus.dmem_req, 32'h1);
        RESET = 1'b1;
        #1;
        check("mr_req_dropped", bus.dmem_req, 32'h0);
        check("mr_cause_clr",   fault_cause,  32'h0);
        check("mr_load_clr",    load_data_M,  32'h0);
        nop();
        next_cycle();
        RESET = 1'b0;
        next_cycle();
        set_m(3'b001, 1'b0, 3'b010, 32'h0000_0108, 32'h0);
        run(1, 32'hCAFE_F00D, n_req, n_stall);
        check("pr_nreq",   n_req,         32'd1);
        check("pr_nstall", n_stall,       32'd2);
        check("pr_addr",   bus.dmem_addr, 32'h0000_0108);
        check("pr_data",   load_data_M,   32'hCAFE_F00D);
        next_cycle();
        nop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
